// File: rtl/i2c_target_mem.sv
// i2c_target_mem: I2C target (slave) with a 256x8 register file.
// Handles bus-address match, register-pointer writes, data writes with
// auto-increment, and combined reads through a repeated START.
// Optional feature macro: I2C_TARGET_WP_EN (write-protects 0xF0-0xFF).
module i2c_target_mem #(
    parameter logic [6:0]  TARGET_ADDR = 7'h55,
    parameter logic [7:0]  MEM_INIT    = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       nack_sent
);

    // Synchronizer depth never drops below two flops.
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [SYNC_N-1:0] r_scl_sync;
    logic [SYNC_N-1:0] r_sda_sync;
    logic              r_scl_prev;
    logic              r_sda_prev;
    logic              w_scl_s;
    logic              w_sda_s;

    logic              w_rise;
    logic              w_fall;
    logic              w_start;
    logic              w_stop;
    logic              w_evt_ok;

    logic [3:0]        r_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_in;
    logic [7:0]        r_ptr;
    logic [7:0]        w_ptr_inc;
    logic              r_rw;
    logic              r_mack;
    logic              r_sda_oe;
    logic              w_sda_oe_next;
    logic              w_addr_match;

    logic [7:0]        r_mem [256];
    logic [7:0]        w_mem_rd;
    logic [7:0]        w_mem_next;
    logic              w_mem_we;
    logic              w_wp_hit;

    logic              r_busy;
    logic              r_wr_strobe;
    logic [7:0]        r_wr_addr;
    logic [7:0]        r_wr_data;

    // Open-drain pad: only ever pull low or release.
    assign SDA = r_sda_oe ? 1'b0 : 1'bz;

    // Pin synchronizers plus previous-value registers for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_N-2:0], SCL};
            r_sda_sync <= {r_sda_sync[SYNC_N-2:0], SDA};
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
        end
    end

    assign w_scl_s = r_scl_sync[SYNC_N-1];
    assign w_sda_s = r_sda_sync[SYNC_N-1];

    // SCL must be high on both samples so a simultaneous SCL/SDA move is
    // never mistaken for a bus condition.
    assign w_rise   =  w_scl_s & ~r_scl_prev;
    assign w_fall   = ~w_scl_s &  r_scl_prev;
    assign w_start  =  w_scl_s &  r_scl_prev &  r_sda_prev & ~w_sda_s;
    assign w_stop   =  w_scl_s &  r_scl_prev & ~r_sda_prev &  w_sda_s;
    assign w_evt_ok = ~w_start & ~w_stop;

    assign w_shift_in   = {r_shift[6:0], w_sda_s};
    assign w_ptr_inc    = r_ptr + 8'd1;
    assign w_addr_match = (r_shift[7:1] == TARGET_ADDR);
    assign w_mem_rd     = r_mem[r_ptr];
    assign w_mem_next   = r_mem[w_ptr_inc];

`ifdef I2C_TARGET_WP_EN
    assign w_wp_hit = (r_ptr[7:4] == 4'hF);
`else
    assign w_wp_hit = 1'b0;
`endif

    // Register-file write happens on the 8th SCL rise of a data byte.
    assign w_mem_we = (r_state == ST_WDATA) && w_evt_ok && w_rise &&
                      (r_cnt == 4'd7) && !w_wp_hit;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and SDA drive decisions; SDA only changes on SCL falls
    // or on bus conditions.
    always_comb begin
        w_state_next  = r_state;
        w_sda_oe_next = r_sda_oe;
        if (w_stop) begin
            w_state_next  = ST_IDLE;
            w_sda_oe_next = 1'b0;
        end else if (w_start) begin
            w_state_next  = ST_ADDR;
            w_sda_oe_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_sda_oe_next = 1'b0;
                end
                ST_ADDR: begin
                    if (w_fall && r_cnt == 4'd8) begin
                        if (w_addr_match) begin
                            w_state_next  = ST_ADDR_ACK;
                            w_sda_oe_next = 1'b1;
                        end else begin
                            w_state_next  = ST_WAIT_STOP;
                            w_sda_oe_next = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_fall) begin
                        if (r_rw) begin
                            w_state_next  = ST_RDATA;
                            w_sda_oe_next = ~w_mem_rd[7];
                        end else begin
                            w_state_next  = ST_REG;
                            w_sda_oe_next = 1'b0;
                        end
                    end
                end
                ST_REG: begin
                    if (w_fall && r_cnt == 4'd8) begin
                        w_state_next  = ST_REG_ACK;
                        w_sda_oe_next = 1'b1;
                    end
                end
                ST_REG_ACK: begin
                    if (w_fall) begin
                        w_state_next  = ST_WDATA;
                        w_sda_oe_next = 1'b0;
                    end
                end
                ST_WDATA: begin
                    if (w_fall && r_cnt == 4'd8) begin
                        if (w_wp_hit) begin
                            w_state_next  = ST_WAIT_STOP;
                            w_sda_oe_next = 1'b0;
                        end else begin
                            w_state_next  = ST_WDATA_ACK;
                            w_sda_oe_next = 1'b1;
                        end
                    end
                end
                ST_WDATA_ACK: begin
                    if (w_fall) begin
                        w_state_next  = ST_WDATA;
                        w_sda_oe_next = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (w_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_state_next  = ST_RDATA_ACK;
                            w_sda_oe_next = 1'b0;
                        end else begin
                            w_sda_oe_next = ~r_shift[6];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_fall) begin
                        if (!r_mack) begin
                            w_state_next  = ST_RDATA;
                            w_sda_oe_next = ~w_mem_next[7];
                        end else begin
                            w_state_next  = ST_WAIT_STOP;
                            w_sda_oe_next = 1'b0;
                        end
                    end
                end
                ST_WAIT_STOP: begin
                    w_sda_oe_next = 1'b0;
                end
                default: begin
                    w_state_next  = ST_IDLE;
                    w_sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    // Bit counter, shift register, pointer, busy and SDA drive register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_shift  <= '0;
            r_ptr    <= '0;
            r_rw     <= 1'b0;
            r_mack   <= 1'b1;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_sda_oe <= w_sda_oe_next;
            if (!w_evt_ok) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        if (w_rise && r_cnt < 4'd8) begin
                            r_shift <= w_shift_in;
                            r_cnt   <= r_cnt + 4'd1;
                        end
                        if (w_fall && r_cnt == 4'd8) begin
                            if (r_state == ST_ADDR && w_addr_match) begin
                                r_busy <= 1'b1;
                                r_rw   <= r_shift[0];
                            end
                            if (r_state == ST_REG) begin
                                r_ptr <= r_shift;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_fall) begin
                            r_cnt <= '0;
                            if (r_rw) begin
                                r_shift <= w_mem_rd;
                            end
                        end
                    end
                    ST_REG_ACK: begin
                        if (w_fall) begin
                            r_cnt <= '0;
                        end
                    end
                    ST_WDATA_ACK: begin
                        if (w_fall) begin
                            r_cnt <= '0;
                            r_ptr <= w_ptr_inc;
                        end
                    end
                    ST_RDATA: begin
                        if (w_rise && r_cnt < 4'd8) begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                        if (w_fall && r_cnt != 4'd8) begin
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (w_rise) begin
                            r_mack <= w_sda_s;
                        end
                        if (w_fall) begin
                            r_cnt <= '0;
                            if (!r_mack) begin
                                r_ptr   <= w_ptr_inc;
                                r_shift <= w_mem_next;
                            end
                        end
                    end
                    default: begin
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Register file with asynchronous initialisation to MEM_INIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 256; i++) begin
                r_mem[i] <= MEM_INIT;
            end
        end else if (w_mem_we) begin
            r_mem[r_ptr] <= w_shift_in;
        end
    end

    // Write-report outputs: one-clk strobe, address/data held until next write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_strobe <= w_mem_we;
            if (w_mem_we) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_shift_in;
            end
        end
    end

`ifdef I2C_TARGET_WP_EN
    logic r_nack_sent;

    // One-clk pulse when a data byte aimed at a protected register is refused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nack_sent <= 1'b0;
        end else begin
            r_nack_sent <= (r_state == ST_WDATA) && w_evt_ok && w_rise &&
                           (r_cnt == 4'd7) && w_wp_hit;
        end
    end

    assign nack_sent = r_nack_sent;
`else
    assign nack_sent = 1'b0;
`endif

    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

endmodule
